// File: rtl/apb_multi_slave_mem_pkg.sv
// Shared types and helpers for the apb_multi_slave_mem APB4 completer.
package apb_multi_slave_mem_pkg;

    // Completer-side transfer state: waiting for a setup, or inside the access phase
    typedef enum logic {
        APB_SLV_IDLE,
        APB_SLV_ACCESS
    } apb_slv_state_e;

    localparam int BYTE_WIDTH = 8;

    // Number of byte strobes (and byte lanes) for a given data bus width
    function automatic int strb_width(input int data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/apb_multi_slave_mem_bank.sv
// One memory bank: byte-lane writes on the clock edge, combinational read of the addressed word.
// No reset; contents are undefined until written.
module apb_multi_slave_mem_bank
    import apb_multi_slave_mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int WORD_AW     = 6
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [strb_width(DATA_WIDTH)-1:0]   be,
    input  logic [WORD_AW-1:0]                  word_addr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    output logic [DATA_WIDTH-1:0]               rdata
);

    localparam int STRB_W = strb_width(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Update only the byte lanes whose enable is set
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (be[k]) begin
                    mem[word_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign rdata = mem[word_addr];

endmodule

// File: rtl/apb_multi_slave_mem.sv
// APB4 completer with NO_OF_SLAVES independent byte-addressable banks, one pselx bit each.
// Run-time wait states, pstrb byte-lane writes, pslverr on illegal accesses.
// Optional feature macro: APB_PROT_CHECK_EN (non-secure access to a secure bank is an error).
module apb_multi_slave_mem
    import apb_multi_slave_mem_pkg::*;
#(
    parameter int                    NO_OF_SLAVES     = 4,
    parameter int                    ADDRESS_WIDTH    = 32,
    parameter int                    DATA_WIDTH       = 32,
    parameter int                    MEM_DEPTH_BYTES  = 256,
    parameter int                    WAIT_WIDTH       = 3,
    parameter logic [NO_OF_SLAVES-1:0] SECURE_BANK_MASK = '0
) (
    input  logic                              pclk,
    input  logic                              preset_n,
    input  logic [NO_OF_SLAVES-1:0]           pselx,
    input  logic                              penable,
    input  logic                              pwrite,
    input  logic [ADDRESS_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]             pwdata,
    input  logic [strb_width(DATA_WIDTH)-1:0] pstrb,
    input  logic [2:0]                        pprot,
    input  logic [WAIT_WIDTH-1:0]             wait_states,
    output logic                              pready,
    output logic [DATA_WIDTH-1:0]             prdata,
    output logic                              pslverr
);

    localparam int STRB_W      = strb_width(DATA_WIDTH);
    localparam int BYTE_OFF_W  = $clog2(STRB_W);
    localparam int MEM_AW      = $clog2(MEM_DEPTH_BYTES);
    localparam int DEPTH_WORDS = MEM_DEPTH_BYTES / STRB_W;
    localparam int WORD_AW     = (MEM_AW > BYTE_OFF_W) ? (MEM_AW - BYTE_OFF_W) : 1;
    localparam int IDX_W       = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
    localparam logic [WAIT_WIDTH-1:0] CNT_ONE = WAIT_WIDTH'(1);

    apb_slv_state_e             state_q, state_d;
    logic [IDX_W-1:0]           bank_q, bank_d, sel_idx, cur_bank;
    logic [MEM_AW-1:0]          offset_q, offset_d, cur_offset, word_full;
    logic                       write_q, write_d, cur_write;
    logic [STRB_W-1:0]          strb_q, strb_d, cur_strb;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d, cur_wdata;
    logic                       err_q, err_d, cur_err, setup_err;
    logic [WAIT_WIDTH-1:0]      cnt_q, cnt_d;
    logic                       pready_q, pready_d;
    logic                       pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]      prdata_q, prdata_d;
    logic                       commit;
    logic [WORD_AW-1:0]         word_addr;
    logic [NO_OF_SLAVES-1:0][DATA_WIDTH-1:0] bank_rdata;
    logic                       unused_bits;

    // Lowest selected bank wins; only meaningful when pselx is one-hot
    always_comb begin
        sel_idx = '0;
        for (int i = NO_OF_SLAVES - 1; i >= 0; i--) begin
            if (pselx[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Illegal-access check for a transfer being set up this cycle
    always_comb begin
        setup_err = !$onehot(pselx) || ((paddr >> MEM_AW) != '0);
`ifdef APB_PROT_CHECK_EN
        if (pprot[1] && SECURE_BANK_MASK[sel_idx]) begin
            setup_err = 1'b1;
        end
`endif
    end

    // Next-state, wait counting and response generation; commit marks the edge that raises pready
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        offset_d   = offset_q;
        write_d    = write_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        commit     = 1'b0;
        cur_bank   = bank_q;
        cur_offset = offset_q;
        cur_write  = write_q;
        cur_strb   = strb_q;
        cur_wdata  = wdata_q;
        cur_err    = err_q;

        case (state_q)
            APB_SLV_IDLE: begin
                // A zero-wait transfer completes on the setup edge, so use the live bus here
                cur_bank   = sel_idx;
                cur_offset = paddr[MEM_AW-1:0];
                cur_write  = pwrite;
                cur_strb   = pstrb;
                cur_wdata  = pwdata;
                cur_err    = setup_err;
                pready_d   = 1'b0;
                pslverr_d  = 1'b0;
                if (|pselx && !penable) begin
                    bank_d   = cur_bank;
                    offset_d = cur_offset;
                    write_d  = cur_write;
                    strb_d   = cur_strb;
                    wdata_d  = cur_wdata;
                    err_d    = cur_err;
                    cnt_d    = wait_states;
                    pready_d = (wait_states == '0);
                    commit   = (wait_states == '0);
                    state_d  = APB_SLV_ACCESS;
                end
            end
            APB_SLV_ACCESS: begin
                if (pready_q) begin
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    state_d   = APB_SLV_IDLE;
                end else if (pselx == '0) begin
                    cnt_d   = '0;
                    state_d = APB_SLV_IDLE;
                end else begin
                    cnt_d    = cnt_q - CNT_ONE;
                    pready_d = (cnt_q == CNT_ONE);
                    commit   = (cnt_q == CNT_ONE);
                end
            end
            default: begin
                state_d = APB_SLV_IDLE;
            end
        endcase

        if (commit) begin
            pslverr_d = cur_err;
            if (cur_err) begin
                prdata_d = '0;
            end else if (!cur_write) begin
                prdata_d = bank_rdata[cur_bank];
            end
        end
    end

    // Transfer state and response registers
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= APB_SLV_IDLE;
            bank_q    <= '0;
            offset_q  <= '0;
            write_q   <= 1'b0;
            strb_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            bank_q    <= bank_d;
            offset_q  <= offset_d;
            write_q   <= write_d;
            strb_q    <= strb_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign word_full   = cur_offset >> BYTE_OFF_W;
    assign word_addr   = word_full[WORD_AW-1:0];
    assign unused_bits = ^{word_full, pprot};

    for (genvar i = 0; i < NO_OF_SLAVES; i++) begin : g_bank
        apb_multi_slave_mem_bank #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DEPTH_WORDS (DEPTH_WORDS),
            .WORD_AW     (WORD_AW)
        ) u_bank (
            .clk       (pclk),
            .we        (commit && cur_write && !cur_err && (cur_bank == IDX_W'(i))),
            .be        (cur_strb),
            .word_addr (word_addr),
            .wdata     (cur_wdata),
            .rdata     (bank_rdata[i])
        );
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_multi_slave_mem.sv
// Self-checking bench for apb_multi_slave_mem: directed scenarios plus randomized transfers
// compared against a byte-array reference memory.
module tb_apb_multi_slave_mem;

    localparam logic [3:0] SECURE_MASK = 4'b0010;
`ifdef APB_PROT_CHECK_EN
    localparam bit PROT_CHECK = 1'b1;
`else
    localparam bit PROT_CHECK = 1'b0;
`endif

    logic        pclk;
    logic        preset_n;
    logic [3:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [2:0]  wait_states;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int          numChecks;
    int          numErrors;
    logic [7:0]  refMem [4][256];
    logic [31:0] refPrdata;

    apb_multi_slave_mem #(
        .NO_OF_SLAVES     (4),
        .ADDRESS_WIDTH    (32),
        .DATA_WIDTH       (32),
        .MEM_DEPTH_BYTES  (256),
        .WAIT_WIDTH       (3),
        .SECURE_BANK_MASK (SECURE_MASK)
    ) dut (
        .pclk        (pclk),
        .preset_n    (preset_n),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .wait_states (wait_states),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    // Free-running APB clock, 10 ns period
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Single comparison point: count it, report a mismatch
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h", tag, actual, expected);
        end
    endtask

    // Reference rule: an access is illegal if the select is not one-hot, the address is
    // beyond the bank, or (with protection checking) a non-secure access hits a secure bank
    function automatic bit refErr(input logic [3:0] sel, input logic [31:0] addr, input logic [2:0] prot);
        bit e;
        e = ($countones(sel) != 1) || (addr >= 32'd256);
        if (PROT_CHECK && prot[1] && ((sel & SECURE_MASK) != 4'b0)) e = 1'b1;
        return e;
    endfunction

    function automatic int bankOf(input logic [3:0] sel);
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [31:0] refWord(input int bank, input logic [31:0] addr);
        logic [31:0] w;
        int base;
        base = int'(addr[7:2]) * 4;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = refMem[bank][base + k];
        return w;
    endfunction

    // One complete APB transfer; accSel is what pselx shows during the access phase.
    // Bus fields other than pselx/penable are scrambled in the access phase.
    task automatic applyStimulus(input logic [3:0] sel, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic [2:0] prot, input int waitN, input logic [3:0] accSel);
        int          cyc;
        bit          expErr;
        int          bank;
        int          base;
        logic [31:0] expData;
        expErr = refErr(sel, addr, prot);
        bank   = bankOf(sel);
        base   = int'(addr[7:2]) * 4;
        pselx = sel; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        pstrb = strb; pprot = prot; wait_states = 3'(waitN);
        @(posedge pclk); #1;
        penable = 1'b1; pselx = accSel;
        paddr = $urandom; pwdata = $urandom; pstrb = 4'($urandom);
        pprot = 3'($urandom); wait_states = 3'($urandom); pwrite = 1'($urandom);
        cyc = 1;
        forever begin
            @(negedge pclk);
            if (pready === 1'b1) break;
            if (cyc >= 20) break;
            @(posedge pclk); #1;
            cyc++;
        end
        checkOutput("latency", 32'(cyc), 32'(waitN + 1));
        if (pready === 1'b1) begin
            if (expErr) begin
                refPrdata = '0;
            end else if (wr) begin
                for (int k = 0; k < 4; k++) begin
                    if (strb[k]) refMem[bank][base + k] = wdata[k*8 +: 8];
                end
            end else begin
                refPrdata = refWord(bank, addr);
            end
            expData = refPrdata;
            checkOutput("pslverr", 32'(pslverr), 32'(expErr));
            checkOutput("prdata", prdata, expData);
        end
        @(posedge pclk); #1;
    endtask

    // Park the bus for n cycles; no response may appear
    task automatic goIdle(input int n);
        pselx = 4'b0; penable = 1'b0;
        repeat (n) begin
            @(negedge pclk);
            checkOutput("idle_pready", 32'(pready), 32'd0);
            checkOutput("idle_pslverr", 32'(pslverr), 32'd0);
            @(posedge pclk); #1;
        end
    endtask

    // Start a 5-wait write and cancel it either by dropping pselx or by asserting reset
    task automatic abortTransfer(input logic [3:0] sel, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit useReset);
        pselx = sel; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wdata;
        pstrb = 4'hF; pprot = 3'b0; wait_states = 3'd5;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) begin
            @(negedge pclk);
            checkOutput("abort_wait_pready", 32'(pready), 32'd0);
            @(posedge pclk); #1;
        end
        if (useReset) begin
            preset_n = 1'b0;
            #1;
            checkOutput("rst_mid_pready", 32'(pready), 32'd0);
            checkOutput("rst_mid_prdata", prdata, 32'd0);
            checkOutput("rst_mid_pslverr", 32'(pslverr), 32'd0);
            refPrdata = '0;
            @(posedge pclk); #1;
            pselx = 4'b0; penable = 1'b0; preset_n = 1'b1;
        end else begin
            pselx = 4'b0; penable = 1'b0;
        end
        repeat (8) begin
            @(negedge pclk);
            checkOutput("abort_pready", 32'(pready), 32'd0);
            checkOutput("abort_prdata", prdata, refPrdata);
            @(posedge pclk); #1;
        end
    endtask

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  sel;
        logic [3:0]  accSel;
        logic [31:0] addr;
        numChecks = 0;
        numErrors = 0;
        refPrdata = '0;
        preset_n = 1'b0; pselx = 4'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = 4'b0; pprot = 3'b0; wait_states = 3'b0;
        #12;
        checkOutput("reset_pready", 32'(pready), 32'd0);
        checkOutput("reset_prdata", prdata, 32'd0);
        checkOutput("reset_pslverr", 32'(pslverr), 32'd0);
        @(posedge pclk); #1;
        preset_n = 1'b1;
        goIdle(2);

        $display("[TB] preload words 0..15 of every bank");
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 16; w++) begin
                sel = 4'(1 << b);
                applyStimulus(sel, 1'b1, 32'(w * 4), $urandom, 4'hF, 3'b0, 0, sel);
            end
        end

        $display("[TB] full write and readback, zero wait");
        applyStimulus(4'b0001, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 3'b0, 0, 4'b0001);
        applyStimulus(4'b0001, 1'b0, 32'h10, 32'h0, 4'h0, 3'b0, 0, 4'b0001);
        checkOutput("t1_data", prdata, 32'hA5A5_1234);

        $display("[TB] partial strobes with three wait states");
        applyStimulus(4'b0100, 1'b1, 32'h20, 32'h0, 4'hF, 3'b0, 0, 4'b0100);
        applyStimulus(4'b0100, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0101, 3'b0, 3, 4'b0100);
        applyStimulus(4'b0100, 1'b0, 32'h22, 32'h0, 4'h0, 3'b0, 2, 4'b0100);
        checkOutput("t2_data", prdata, 32'h00FF_00FF);
        applyStimulus(4'b0100, 1'b1, 32'h20, 32'h1234_5678, 4'b0000, 3'b0, 1, 4'b0100);
        applyStimulus(4'b0100, 1'b0, 32'h20, 32'h0, 4'h0, 3'b0, 0, 4'b0100);
        checkOutput("t2_nostrb", prdata, 32'h00FF_00FF);

        $display("[TB] illegal selects and out-of-range addresses");
        applyStimulus(4'b0011, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b0, 0, 4'b0011);
        applyStimulus(4'b0001, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 3'b0, 2, 4'b0001);
        applyStimulus(4'b0001, 1'b0, 32'h10, 32'h0, 4'h0, 3'b0, 0, 4'b0001);
        checkOutput("t3_unchanged", prdata, 32'hA5A5_1234);
        applyStimulus(4'b0001, 1'b0, 32'h104, 32'h0, 4'h0, 3'b0, 1, 4'b0001);

        $display("[TB] back-to-back bank0 write then bank3 read");
        applyStimulus(4'b0001, 1'b1, 32'h3C, 32'hCAFE_F00D, 4'hF, 3'b0, 0, 4'b0001);
        applyStimulus(4'b1000, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b0, 0, 4'b1000);
        applyStimulus(4'b0001, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b0, 4, 4'b0001);
        checkOutput("t4_data", prdata, 32'hCAFE_F00D);
        goIdle(1);

        $display("[TB] bank switch during access is ignored");
        applyStimulus(4'b0010, 1'b1, 32'h08, 32'h0BAD_C0DE, 4'hF, 3'b0, 3, 4'b1000);
        applyStimulus(4'b0010, 1'b0, 32'h08, 32'h0, 4'h0, 3'b0, 0, 4'b0010);

        $display("[TB] penable without setup");
        pselx = 4'b0001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h5555_AAAA; pstrb = 4'hF; wait_states = 3'd0;
        repeat (3) begin
            @(negedge pclk);
            checkOutput("nosetup_pready", 32'(pready), 32'd0);
            @(posedge pclk); #1;
        end
        goIdle(1);
        applyStimulus(4'b0001, 1'b0, 32'h10, 32'h0, 4'h0, 3'b0, 0, 4'b0001);

        $display("[TB] abort by pselx drop and by reset");
        abortTransfer(4'b0001, 32'h10, 32'h7777_7777, 1'b0);
        applyStimulus(4'b0001, 1'b0, 32'h10, 32'h0, 4'h0, 3'b0, 0, 4'b0001);
        abortTransfer(4'b0100, 32'h20, 32'h6666_6666, 1'b1);
        applyStimulus(4'b0100, 1'b0, 32'h20, 32'h0, 4'h0, 3'b0, 1, 4'b0100);

        $display("[TB] protection on secure bank 1");
        applyStimulus(4'b0010, 1'b1, 32'h30, 32'h1111_2222, 4'hF, 3'b010, 0, 4'b0010);
        applyStimulus(4'b0010, 1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 0, 4'b0010);
        applyStimulus(4'b0010, 1'b1, 32'h30, 32'h3333_4444, 4'hF, 3'b000, 1, 4'b0010);
        applyStimulus(4'b0010, 1'b0, 32'h30, 32'h0, 4'h0, 3'b010, 0, 4'b0010);

        $display("[TB] randomized transfers");
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) sel = 4'(4'b0011 << $urandom_range(0, 2));
            else sel = 4'(1 << $urandom_range(0, 3));
            accSel = sel;
            if ($urandom_range(0, 4) == 0) accSel = 4'(1 << $urandom_range(0, 3));
            addr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'h100 << $urandom_range(0, 20));
            applyStimulus(sel, 1'($urandom), addr, $urandom, 4'($urandom), 3'($urandom),
                          int'($urandom_range(0, 7)), accSel);
            if ($urandom_range(0, 2) != 0) goIdle(int'($urandom_range(1, 2)));
        end
        goIdle(2);

        $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
        $finish;
    end

endmodule
